vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing_ctrl_pix_tick_gen.sv | 34 +++
 rtl/vga_timing_ctrl.sv | 132 +++++++++++++
 tb/tb_vga_timing_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Brief   : Default 640x480@60 timing constants and the line-phase encoding.
// Revision: 1.0
// ============================================================================
package vga_pkg;

  localparam int C_DIV    = 4;
  localparam int C_H_VIS  = 640;
  localparam int C_H_FP   = 16;
  localparam int C_H_SYNC = 96;
  localparam int C_H_BP   = 48;
  localparam int C_V_VIS  = 480;
  localparam int C_V_FP   = 10;
  localparam int C_V_SYNC = 2;
  localparam int C_V_BP   = 33;

  localparam int C_H_TOTAL      = C_H_VIS + C_H_FP + C_H_SYNC + C_H_BP;
  localparam int C_V_TOTAL      = C_V_VIS + C_V_FP + C_V_SYNC + C_V_BP;
  localparam int C_H_SYNC_START = C_H_VIS + C_H_FP;
  localparam int C_H_SYNC_END   = C_H_SYNC_START + C_H_SYNC;
  localparam int C_V_SYNC_START = C_V_VIS + C_V_FP;
  localparam int C_V_SYNC_END   = C_V_SYNC_START + C_V_SYNC;

  typedef enum logic [1:0] {
    PH_VISIBLE = 2'd0,
    PH_FRONT   = 2'd1,
    PH_SYNC    = 2'd2,
    PH_BACK    = 2'd3
  } line_phase_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_ctrl_pix_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : pix_tick_gen
// Brief   : Clock divider producing a one-clk pixel enable every DIV clocks.
// Revision: 1.0
// ============================================================================
module pix_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pix_tick
);

  localparam int              CW     = $clog2(DIV);
  localparam logic [CW-1:0]   C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (!en || (r_div_cnt >= C_LAST)) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  assign pix_tick = (r_div_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_ctrl
// Brief   : VGA raster scan generator with registered, zero-latency syncs.
// Revision: 1.0
// ============================================================================
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int DIV    = C_DIV,
  parameter int H_VIS  = C_H_VIS,
  parameter int H_FP   = C_H_FP,
  parameter int H_SYNC = C_H_SYNC,
  parameter int H_BP   = C_H_BP,
  parameter int V_VIS  = C_V_VIS,
  parameter int V_FP   = C_V_FP,
  parameter int V_SYNC = C_V_SYNC,
  parameter int V_BP   = C_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam logic [9:0] C_H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] C_V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] C_H_VISL = 10'(H_VIS);
  localparam logic [9:0] C_V_VISL = 10'(V_VIS);
  localparam logic [9:0] C_HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] C_HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] C_VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] C_VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic        w_tick;
  logic [9:0]  r_h, r_v, w_h_nxt, w_v_nxt;
  line_phase_t r_phase, w_phase_nxt;
  logic        r_hsync, r_vsync, r_video;
  logic        w_hsync_nxt, w_vsync_nxt, w_video_nxt;

  pix_tick_gen #(
    .DIV(DIV)
  ) u_pix_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .pix_tick(w_tick)
  );

  // Out-of-range counts collapse to 0 on the next tick.
  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (!en) begin
      w_h_nxt = '0;
      w_v_nxt = '0;
    end else if (w_tick) begin
      if (r_h >= C_H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v >= C_V_LAST) ? 10'd0 : r_v + 10'd1;
      end else begin
        w_h_nxt = r_h + 10'd1;
        w_v_nxt = (r_v > C_V_LAST) ? 10'd0 : r_v;
      end
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    if (!en) begin
      w_phase_nxt = PH_VISIBLE;
    end else if (w_tick) begin
      case (r_phase)
        PH_VISIBLE: if (w_h_nxt == C_H_VISL) w_phase_nxt = PH_FRONT;
        PH_FRONT:   if (w_h_nxt == C_HS_BEG) w_phase_nxt = PH_SYNC;
        PH_SYNC:    if (w_h_nxt == C_HS_END) w_phase_nxt = PH_BACK;
        PH_BACK:    if (w_h_nxt == 10'd0)    w_phase_nxt = PH_VISIBLE;
        default:    w_phase_nxt = PH_VISIBLE;
      endcase
    end
  end

  // Sync/blank are decoded from next-state values so they land with x/y.
  always_comb begin
    w_hsync_nxt = r_hsync;
    w_vsync_nxt = r_vsync;
    w_video_nxt = r_video;
    if (!en) begin
      w_hsync_nxt = 1'b1;
      w_vsync_nxt = 1'b1;
      w_video_nxt = 1'b0;
    end else if (w_tick) begin
      w_hsync_nxt = (w_phase_nxt != PH_SYNC);
      w_vsync_nxt = !((w_v_nxt >= C_VS_BEG) && (w_v_nxt < C_VS_END));
      w_video_nxt = (w_h_nxt < C_H_VISL) && (w_v_nxt < C_V_VISL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h     <= '0;
      r_v     <= '0;
      r_phase <= PH_VISIBLE;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_video <= 1'b0;
    end else begin
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
      r_phase <= w_phase_nxt;
      r_hsync <= w_hsync_nxt;
      r_vsync <= w_vsync_nxt;
      r_video <= w_video_nxt;
    end
  end

  assign pix_tick    = w_tick;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video;
  assign x           = r_h;
  assign y           = r_v;
  assign frame_start = w_tick && (r_h == 10'd0) && (r_v == 10'd0);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_timing_ctrl
// Brief   : Reduced-timing and default-timing instances against a scan model.
// Revision: 1.0
// ============================================================================
module tb_vga_timing_ctrl;

  typedef struct {
    bit tick, hs, vs, vid, fs;
    int x, y;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, en_a = 1'b1, rst_b = 1'b0, en_b = 1'b1;
  logic       tick_a, hs_a, vs_a, vid_a, fs_a;
  logic       tick_b, hs_b, vs_b, vid_b, fs_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  int         checks = 0, failures = 0;
  int         n_a = 0, n_b = 0;
  bit         a_done = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .DIV(2), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_a), .en(en_a), .pix_tick(tick_a), .hsync(hs_a),
    .vsync(vs_a), .video_on(vid_a), .x(x_a), .y(y_a), .frame_start(fs_a)
  );

  vga_timing_ctrl u_dut_b (
    .clk(clk), .rst_n(rst_b), .en(en_b), .pix_tick(tick_b), .hsync(hs_b),
    .vsync(vs_b), .video_on(vid_b), .x(x_b), .y(y_b), .frame_start(fs_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Scan position follows from the number of enabled edges since the origin.
  function automatic exp_t model(input int n, input int div, input int hv, input int hf,
                                 input int hsl, input int hb, input int vv, input int vf,
                                 input int vsl, input int vb);
    exp_t e;
    int ht, vt, t, h, v;
    ht = hv + hf + hsl + hb;
    vt = vv + vf + vsl + vb;
    t  = n / div;
    h  = t % ht;
    v  = (t / ht) % vt;
    e.tick = ((n % div) == div - 1);
    e.x    = h;
    e.y    = v;
    e.hs   = !((h >= hv + hf) && (h < hv + hf + hsl));
    e.vs   = !((v >= vv + vf) && (v < vv + vf + vsl));
    e.vid  = (t > 0) && (h < hv) && (v < vv);
    e.fs   = e.tick && (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t model_a(input int n);
    return model(n, 2, 4, 1, 2, 1, 3, 1, 1, 1);
  endfunction

  function automatic exp_t model_b(input int n);
    return model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  task automatic cmp_all(input string p, input exp_t e, input logic t, input logic h,
                         input logic v, input logic vo, input logic f,
                         input logic [9:0] xx, input logic [9:0] yy);
    check({p, "_tick"}, int'(t), int'(e.tick));
    check({p, "_hsync"}, int'(h), int'(e.hs));
    check({p, "_vsync"}, int'(v), int'(e.vs));
    check({p, "_video"}, int'(vo), int'(e.vid));
    check({p, "_fstart"}, int'(f), int'(e.fs));
    check({p, "_x"}, int'(xx), e.x);
    check({p, "_y"}, int'(yy), e.y);
  endtask

  always @(posedge clk or negedge rst_a)
    if (!rst_a)     n_a <= 0;
    else if (!en_a) n_a <= 0;
    else            n_a <= n_a + 1;

  always @(posedge clk or negedge rst_b)
    if (!rst_b)     n_b <= 0;
    else if (!en_b) n_b <= 0;
    else            n_b <= n_b + 1;

  always @(negedge clk) begin
    cmp_all("a", model_a(n_a), tick_a, hs_a, vs_a, vid_a, fs_a, x_a, y_a);
    cmp_all("b", model_b(n_b), tick_b, hs_b, vs_b, vid_b, fs_b, x_b, y_b);
  end

  // Reduced-timing instance: frame-level literals, then randomized en/reset.
  initial begin
    int fs1, fs2, vlo, r;
    logic [9:0] px, py;
    logic pt;
    fs1 = -1; fs2 = -1; vlo = 0; px = '0; py = '0; pt = 1'b0;
    wait (rst_a === 1'b1);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (fs_a) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (k <= 96 && !vs_a) vlo++;
      if (k == 2) check("a_cold_x1", int'(x_a), 1);
      if (pt && px == 10'd7 && py == 10'd5) begin
        check("a_wrap_x", int'(x_a), 0);
        check("a_wrap_y", int'(y_a), 0);
      end
      px = x_a; py = y_a; pt = tick_a;
    end
    check("a_first_fstart", fs1, 1);
    check("a_fstart_period", fs2 - fs1, 96);
    check("a_vsync_low_clks", vlo, 16);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      if (!rst_a) rst_a = 1'b1;
      else if (r < 3) en_a = ~en_a;
      else if (!en_a && r < 30) en_a = 1'b1;
      else if (r == 50) begin
        #2 rst_a = 1'b0;
      end
    end
    @(negedge clk);
    rst_a = 1'b1;
    en_a  = 1'b1;
    a_done = 1'b1;
  end

  initial begin
    int ncyc, lo, first_lo, first_vo;
    exp_t e;
    e = model_b(4 * 656);
    check("pin_hs_656", int'(e.hs), 0);
    e = model_b(4 * 752);
    check("pin_hs_752", int'(e.hs), 1);
    e = model_b(4 * 640);
    check("pin_vid_640", int'(e.vid), 0);
    e = model_b(4 * 800 * 490);
    check("pin_vs_490", int'(e.vs), 0);
    e = model_a(95);
    check("pin_a_y", e.y, 5);

    repeat (2) @(negedge clk);
    check("rst_x", int'(x_b), 0);
    check("rst_hsync", int'(hs_b), 1);
    check("rst_vsync", int'(vs_b), 1);
    check("rst_video", int'(vid_b), 0);
    check("rst_tick", int'(tick_b), 0);
    check("rst_fstart", int'(fs_b), 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check("cold_tick_early", int'(tick_b), 0);
    @(negedge clk);
    check("cold_tick", int'(tick_b), 1);
    check("cold_fstart", int'(fs_b), 1);
    @(negedge clk);
    check("cold_x1", int'(x_b), 1);
    check("cold_video", int'(vid_b), 1);

    ncyc = 4; lo = 0; first_lo = -1; first_vo = -1;
    while (y_b == 10'd0 && ncyc < 4000) begin
      @(negedge clk);
      ncyc++;
      if (!hs_b) begin
        if (first_lo < 0) first_lo = int'(x_b);
        lo++;
      end
      if (!vid_b && first_vo < 0 && y_b == 10'd0) first_vo = int'(x_b);
    end
    check("line_period_clks", ncyc, 3200);
    check("hsync_low_clks", lo, 384);
    check("hsync_start_x", first_lo, 656);
    check("video_fall_x", first_vo, 640);
    check("line_wrap_x", int'(x_b), 0);

    for (int i = 0; i < 4000 && x_b != 10'd300; i++) @(negedge clk);
    check("drop_at_x300", int'(x_b), 300);
    en_b = 1'b0;
    @(negedge clk);
    check("drop_x", int'(x_b), 0);
    check("drop_y", int'(y_b), 0);
    check("drop_hsync", int'(hs_b), 1);
    check("drop_video", int'(vid_b), 0);
    en_b = 1'b1;
    repeat (2) @(negedge clk);
    check("reen_fstart_early", int'(fs_b), 0);
    @(negedge clk);
    check("reen_fstart", int'(fs_b), 1);

    for (int i = 0; i < 4000 && x_b != 10'd700; i++) @(negedge clk);
    check("arst_at_x700", int'(x_b), 700);
    check("arst_hsync_pre", int'(hs_b), 0);
    #2 rst_b = 1'b0;
    #1;
    check("arst_hsync", int'(hs_b), 1);
    check("arst_x", int'(x_b), 0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_restart_tick", int'(tick_b), 1);

    for (int i = 0; i < 20000 && !a_done; i++) @(negedge clk);
    check("a_sequence_done", int'(a_done), 1);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
